// File: rtl/alu_op_decoder.sv
// Registered decode-and-issue stage: turns an RV32I ALU-class instruction into an
// operand pair and 5-bit ALU_OP for alu_int, with valid/ready on both sides.
module alu_op_decoder (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] INSTR,
   input  logic [31:0] PC,
   input  logic [31:0] RS1_DATA,
   input  logic [31:0] RS2_DATA,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OP1,
   output logic [31:0] OP2,
   output logic [4:0]  ALU_OP,
   output logic [4:0]  RD_ADDR,
   output logic        REG_WRITE_EN,
   output logic        ILLEGAL,
   output logic [7:0]  ILLEGAL_COUNT
);

   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;
   localparam logic [6:0] OpcLui   = 7'b0110111;
   localparam logic [6:0] OpcAuipc = 7'b0010111;

   localparam logic [6:0] Funct7Base = 7'b0000000;
   localparam logic [6:0] Funct7Alt  = 7'b0100000;

   localparam logic [2:0] Funct3Add = 3'b000;
   localparam logic [2:0] Funct3Sll = 3'b001;
   localparam logic [2:0] Funct3Srx = 3'b101;

   localparam logic [4:0] AluAdd = 5'b00000;
   localparam logic [4:0] AluSra = 5'b01101;
   localparam logic [4:0] AluFwd = 5'b10000;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] shamt;
   logic        unused_rs_fields;

   logic [31:0] op1_d;
   logic [31:0] op2_d;
   logic [4:0]  alu_op_d;
   logic        illegal_d;
   logic        we_d;

   logic        valid_q;
   logic [31:0] op1_q;
   logic [31:0] op2_q;
   logic [4:0]  alu_op_q;
   logic [4:0]  rd_q;
   logic        we_q;
   logic        illegal_q;
   logic [7:0]  ill_cnt_q;

   logic        accept;

   assign opcode = INSTR[6:0];
   assign rd     = INSTR[11:7];
   assign funct3 = INSTR[14:12];
   assign funct7 = INSTR[31:25];
   assign imm_i  = {{20{INSTR[31]}}, INSTR[31:20]};
   assign imm_u  = {INSTR[31:12], 12'b0};
   assign shamt  = {27'b0, INSTR[24:20]};

   // Register indices are consumed upstream by the register-file read.
   assign unused_rs_fields = ^INSTR[19:15];

   assign IN_READY = !valid_q || OUT_READY;
   assign accept   = IN_VALID && IN_READY;

   always_comb begin
      op1_d     = '0;
      op2_d     = '0;
      alu_op_d  = AluAdd;
      illegal_d = 1'b0;
      case (opcode)
         OpcOp: begin
            op1_d    = RS1_DATA;
            op2_d    = RS2_DATA;
            alu_op_d = {1'b0, funct7[5], funct3};
            if (funct7 == Funct7Base) begin
               illegal_d = 1'b0;
            end else if (funct7 == Funct7Alt &&
                         (funct3 == Funct3Add || funct3 == Funct3Srx)) begin
               illegal_d = 1'b0;
            end else begin
               illegal_d = 1'b1;
            end
         end
         OpcOpImm: begin
            op1_d    = RS1_DATA;
            op2_d    = imm_i;
            alu_op_d = {2'b00, funct3};
            if (funct3 == Funct3Sll) begin
               op2_d     = shamt;
               illegal_d = (funct7 != Funct7Base);
            end else if (funct3 == Funct3Srx) begin
               op2_d = shamt;
               if (funct7 == Funct7Alt) begin
                  alu_op_d = AluSra;
               end else if (funct7 != Funct7Base) begin
                  illegal_d = 1'b1;
               end
            end
         end
         OpcLui: begin
            op1_d    = imm_u;
            alu_op_d = AluFwd;
         end
         OpcAuipc: begin
            op1_d = PC;
            op2_d = imm_u;
         end
         default: illegal_d = 1'b1;
      endcase
      // Illegal words issue as a harmless ADD 0,0 with no writeback.
      if (illegal_d) begin
         op1_d    = '0;
         op2_d    = '0;
         alu_op_d = AluAdd;
      end
   end

   assign we_d = !illegal_d && (rd != 5'd0);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid_q   <= 1'b0;
         op1_q     <= '0;
         op2_q     <= '0;
         alu_op_q  <= '0;
         rd_q      <= '0;
         we_q      <= 1'b0;
         illegal_q <= 1'b0;
         ill_cnt_q <= '0;
      end else if (accept) begin
         valid_q   <= 1'b1;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         alu_op_q  <= alu_op_d;
         rd_q      <= rd;
         we_q      <= we_d;
         illegal_q <= illegal_d;
         if (illegal_d && ill_cnt_q != 8'hFF) begin
            ill_cnt_q <= ill_cnt_q + 8'd1;
         end
      end else if (OUT_READY) begin
         valid_q <= 1'b0;
      end
   end

   assign OUT_VALID     = valid_q;
   assign OP1           = op1_q;
   assign OP2           = op2_q;
   assign ALU_OP        = alu_op_q;
   assign RD_ADDR       = rd_q;
   assign REG_WRITE_EN  = we_q;
   assign ILLEGAL       = illegal_q;
   assign ILLEGAL_COUNT = ill_cnt_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: directed vectors, an instruction-level reference model
// and a scoreboard that checks every issued output and the illegal counter.
module tb_alu_op_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [4:0]  alu_op;
   logic [4:0]  rd_addr;
   logic        reg_we;
   logic        illegal;
   logic [7:0]  ill_count;

   int errors = 0;
   int checks = 0;
   int pushed = 0;
   int popped = 0;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  alu;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   always #5 clk = ~clk;

   alu_op_decoder dut (
      .CLK           (clk),
      .RESET         (rst),
      .IN_VALID      (in_valid),
      .IN_READY      (in_ready),
      .INSTR         (instr),
      .PC            (pc),
      .RS1_DATA      (rs1),
      .RS2_DATA      (rs2),
      .OUT_VALID     (out_valid),
      .OUT_READY     (out_ready),
      .OP1           (op1),
      .OP2           (op2),
      .ALU_OP        (alu_op),
      .RD_ADDR       (rd_addr),
      .REG_WRITE_EN  (reg_we),
      .ILLEGAL       (illegal),
      .ILLEGAL_COUNT (ill_count)
   );

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Instruction-level reference: mnemonic rules, arithmetic shifts and masks.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic signed [31:0] s;
      int f3;
      int f7;
      s  = ins;
      f3 = int'(ins[14:12]);
      f7 = int'(ins[31:25]);
      e = '0;
      e.rd  = ins[11:7];
      e.ill = 1'b1;
      case (ins[6:0])
         7'h33: begin
            e.op1 = a;
            e.op2 = b;
            if (f7 == 0) begin
               e.ill = 1'b0;
               e.alu = 5'(f3);
            end else if (f7 == 'h20 && f3 == 0) begin
               e.ill = 1'b0;
               e.alu = 5'd8;
            end else if (f7 == 'h20 && f3 == 5) begin
               e.ill = 1'b0;
               e.alu = 5'd13;
            end
         end
         7'h13: begin
            e.op1 = a;
            if (f3 == 1 || f3 == 5) begin
               e.op2 = (ins >> 20) & 32'd31;
               if (f7 == 0) begin
                  e.ill = 1'b0;
                  e.alu = 5'(f3);
               end else if (f7 == 'h20 && f3 == 5) begin
                  e.ill = 1'b0;
                  e.alu = 5'd13;
               end
            end else begin
               e.ill = 1'b0;
               e.op2 = s >>> 20;
               e.alu = 5'(f3);
            end
         end
         7'h37: begin
            e.ill = 1'b0;
            e.op1 = ins & 32'hFFFFF000;
            e.alu = 5'd16;
         end
         7'h17: begin
            e.ill = 1'b0;
            e.op1 = p;
            e.op2 = ins & 32'hFFFFF000;
         end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) begin
         e.op1 = 0;
         e.op2 = 0;
         e.alu = 0;
      end
      e.we = !e.ill && (e.rd != 0);
      return e;
   endfunction

   // Scoreboard, sampled on the falling edge.
   exp_t        sb_q[$];
   int          mcnt = 0;
   bit          armed = 1'b0;
   bit          prev_stall = 1'b0;
   logic [84:0] prev_snap;

   always @(negedge clk) begin
      exp_t        cur;
      exp_t        e;
      logic [84:0] snap;
      cur  = {op1, op2, alu_op, rd_addr, reg_we, illegal};
      snap = {out_valid, ill_count, cur};
      if (rst) begin
         sb_q.delete();
         mcnt       = 0;
         armed      = 1'b1;
         prev_stall = 1'b0;
      end else if (armed) begin
         chk("in_ready", 96'(in_ready), 96'(!out_valid || out_ready));
         chk("ill_count", 96'(ill_count), 96'(mcnt));
         if (prev_stall) chk("stall_hold", 96'(snap), 96'(prev_snap));
         chk("valid_vs_queue", 96'(out_valid), 96'(sb_q.size() != 0));
         if (out_valid && sb_q.size() != 0) begin
            chk("out_data", 96'(cur), 96'(sb_q[0]));
            if (out_ready) begin
               void'(sb_q.pop_front());
               popped++;
            end
         end
         if (in_valid && in_ready) begin
            e = model(instr, pc, rs1, rs2);
            sb_q.push_back(e);
            pushed++;
            if (e.ill && mcnt < 255) mcnt++;
         end
         prev_stall = out_valid && !out_ready;
         prev_snap  = snap;
      end
   end

   task automatic send(input logic [31:0] w, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      in_valid = 1'b1;
      instr    = w;
      pc       = p;
      rs1      = a;
      rs2      = b;
      while (!ok && n < 20) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got not-accepted expected accepted for %h", w);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   base;
      rst       = 1'b1;
      in_valid  = 1'b1;
      instr     = 32'hFFFF_FFFF;
      pc        = 32'h0;
      rs1       = 32'h1234_5678;
      rs2       = 32'h9ABC_DEF0;
      out_ready = 1'b1;

      // Reset with a pending illegal word: nothing accepted or counted.
      idle(2);
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("rst_out_valid", 96'(out_valid), 96'(0));
      chk("rst_data", 96'({op1, op2, alu_op, rd_addr, reg_we, illegal}), 96'(0));
      chk("rst_count", 96'(ill_count), 96'(0));
      idle(1);
      chk("idle_out_valid", 96'(out_valid), 96'(0));

      // Pin the model itself against hand-derived values.
      e = model(32'h402081B3, 32'h0, 32'd10, 32'd3);
      chk("model_sub", 96'({e.alu, e.we, e.ill}), 96'({5'b01000, 1'b1, 1'b0}));
      e = model(32'h40435293, 32'h0, 32'h8000_0000, 32'h0);
      chk("model_srai", 96'({e.op2, e.alu}), 96'({32'd4, 5'b01101}));
      e = model(32'hFFF00093, 32'h0, 32'h0, 32'h0);
      chk("model_addi", 96'(e.op2), 96'(32'hFFFF_FFFF));
      e = model(32'h123453B7, 32'h0, 32'h0, 32'h0);
      chk("model_lui", 96'(e.op1), 96'(32'h1234_5000));

      send(32'h402081B3, 32'h0, 32'd10, 32'd3);
      chk("sub", 96'({out_valid, op1, op2, alu_op, rd_addr, reg_we}),
          96'({1'b1, 32'd10, 32'd3, 5'b01000, 5'd3, 1'b1}));
      send(32'h40435293, 32'h0, 32'h8000_0000, 32'h0);
      chk("srai", 96'({op1, op2, alu_op, rd_addr}), 96'({32'h8000_0000, 32'd4, 5'b01101, 5'd5}));
      send(32'hFFF00093, 32'h0, 32'h0, 32'h0);
      chk("addi_neg", 96'({op2, alu_op, rd_addr, reg_we}), 96'({32'hFFFF_FFFF, 5'd0, 5'd1, 1'b1}));
      send(32'h123453B7, 32'h0, 32'h0, 32'h0);
      chk("lui", 96'({op1, op2, alu_op, rd_addr}), 96'({32'h1234_5000, 32'd0, 5'b10000, 5'd7}));
      send(32'h00001417, 32'h100, 32'h0, 32'h0);
      chk("auipc", 96'({op1, op2, alu_op, rd_addr}), 96'({32'h100, 32'h1000, 5'd0, 5'd8}));
      // ADDI with a funct7-looking immediate is still legal.
      send(32'h40000093, 32'h0, 32'd5, 32'h0);
      chk("addi_hi_imm", 96'({op1, op2, illegal}), 96'({32'd5, 32'h400, 1'b0}));
      // SLLI with funct7=0100000 is illegal; write to x0 never enables writeback.
      send(32'h40109093, 32'h0, 32'd7, 32'h0);
      chk("slli_bad", 96'({illegal, reg_we, ill_count}), 96'({1'b1, 1'b0, 8'd1}));
      send(32'h00000033, 32'h0, 32'd1, 32'd2);
      chk("add_x0", 96'({illegal, reg_we}), 96'({1'b0, 1'b0}));
      idle(1);
      chk("drain", 96'(out_valid), 96'(0));

      // Back-pressure mid-stream.
      base = popped;
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               send(32'h00310033 | ((i + 1) << 7), 32'h0, 32'(i * 100), 32'(i + 1));
            end
         end
         begin
            idle(1);
            out_ready = 1'b0;
            #1;
            chk("bp_in_ready", 96'(in_ready), 96'(0));
            idle(3);
            out_ready = 1'b1;
         end
      join
      idle(2);
      chk("bp_issued", 96'(popped - base), 96'(3));

      // Illegal stream and counter saturation.
      send(32'h022081B3, 32'h0, 32'd4, 32'd5);
      chk("mul", 96'({illegal, reg_we, alu_op, rd_addr, op1, ill_count}),
          96'({1'b1, 1'b0, 5'd0, 5'd3, 32'd0, 8'd2}));
      for (int i = 0; i < 300; i++) begin
         send(32'h0000007F | 32'((i % 32) << 7), 32'h0, 32'(i), 32'(i));
      end
      chk("sat_flags", 96'({illegal, reg_we, alu_op}), 96'({1'b1, 1'b0, 5'd0}));
      idle(2);
      chk("sat_count", 96'(ill_count), 96'(255));

      // Reset while an output is stalled and another word is presented.
      out_ready = 1'b0;
      send(32'h00108093, 32'h0, 32'd1, 32'h0);
      in_valid = 1'b1;
      instr    = 32'hFFFF_FFFF;
      rst      = 1'b1;
      idle(1);
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("midrst_valid", 96'(out_valid), 96'(0));
      chk("midrst_count", 96'(ill_count), 96'(0));
      out_ready = 1'b1;
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
